// File: rtl/gpu_pkg.sv
// Shared types for the memory arbiter: per-channel FSM state encoding and
// default bus widths.
package gpu_pkg;

    typedef enum logic [2:0] {
        CH_IDLE           = 3'd0,
        CH_READ_WAITING   = 3'd1,
        CH_WRITE_WAITING  = 3'd2,
        CH_READ_RELAYING  = 3'd3,
        CH_WRITE_RELAYING = 3'd4
    } channel_state_t;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS requesters. Each
// channel claims one consumer, forwards its request, relays the response, then releases it.
module mem_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data,
    output logic [NUM_CHANNELS-1:0]                   mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                   mem_write_ready
);

    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    // Returns {found, index} of the first set bit of req at or after ptr, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CONSUMERS-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W:0]   j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            j = {1'b0, ptr} + (IDX_W+1)'(k);
            if (j >= (IDX_W+1)'(NUM_CONSUMERS))
                j = j - (IDX_W+1)'(NUM_CONSUMERS);
            if (!found && req[j[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = j[IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    logic [NUM_CONSUMERS-1:0]                 claim_reg;
    logic [NUM_CONSUMERS-1:0]                 write_req;
    logic [NUM_CONSUMERS-1:0]                 req_any;
    logic [NUM_CHANNELS-1:0][2:0]             ch_state;
    logic [NUM_CHANNELS-1:0][IDX_W-1:0]       ch_idx;
    logic [NUM_CHANNELS-1:0][IDX_W-1:0]       rr_ptr;
    logic [NUM_CHANNELS-1:0]                  grant_valid;
    logic [NUM_CHANNELS-1:0]                  grant_read;
    logic [NUM_CHANNELS-1:0][IDX_W-1:0]       grant_idx;
    logic [NUM_CONSUMERS-1:0]                 grant_mask;
    logic [NUM_CONSUMERS-1:0]                 release_mask;
    logic [NUM_CHANNELS-1:0]                  rd_done;
    logic [NUM_CHANNELS-1:0]                  wr_done;
    logic [NUM_CHANNELS-1:0]                  rd_release;
    logic [NUM_CHANNELS-1:0]                  wr_release;
    logic [NUM_CONSUMERS-1:0]                 rd_ready_reg;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  rd_data_reg;
    logic [NUM_CONSUMERS-1:0]                 wr_ready_reg;

    assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign req_any   = consumer_read_valid | write_req;

    // Channels claim in index order; each grant is hidden from higher channels.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        logic [IDX_W:0]           pick;
        taken       = claim_reg;
        pick        = '0;
        grant_valid = '0;
        grant_read  = '0;
        grant_idx   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_state[c] == CH_IDLE) begin
                pick = rr_pick(req_any & ~taken, rr_ptr[c]);
                if (pick[IDX_W]) begin
                    grant_valid[c]              = 1'b1;
                    grant_idx[c]                = pick[IDX_W-1:0];
                    grant_read[c]               = consumer_read_valid[pick[IDX_W-1:0]];
                    taken[pick[IDX_W-1:0]]      = 1'b1;
                end
            end
        end
        grant_mask = taken & ~claim_reg;
    end

    always_comb begin
        rd_done      = '0;
        wr_done      = '0;
        rd_release   = '0;
        wr_release   = '0;
        release_mask = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            rd_done[c]    = (ch_state[c] == CH_READ_WAITING)  && mem_read_ready[c];
            wr_done[c]    = (ch_state[c] == CH_WRITE_WAITING) && mem_write_ready[c];
            rd_release[c] = (ch_state[c] == CH_READ_RELAYING)  && !consumer_read_valid[ch_idx[c]];
            wr_release[c] = (ch_state[c] == CH_WRITE_RELAYING) && !consumer_write_valid[ch_idx[c]];
            if (rd_release[c] || wr_release[c])
                release_mask[ch_idx[c]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            claim_reg <= '0;
        else
            claim_reg <= (claim_reg & ~release_mask) | grant_mask;
    end

    // Consumer-facing handshake registers; a consumer is owned by at most one channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ready_reg <= '0;
            rd_data_reg  <= '0;
            wr_ready_reg <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (rd_done[c]) begin
                    rd_data_reg[ch_idx[c]]  <= mem_read_data[c];
                    rd_ready_reg[ch_idx[c]] <= 1'b1;
                end
                if (rd_release[c])
                    rd_ready_reg[ch_idx[c]] <= 1'b0;
                if (wr_done[c])
                    wr_ready_reg[ch_idx[c]] <= 1'b1;
                if (wr_release[c])
                    wr_ready_reg[ch_idx[c]] <= 1'b0;
            end
        end
    end

    assign consumer_read_ready  = rd_ready_reg;
    assign consumer_read_data   = rd_data_reg;
    assign consumer_write_ready = (WRITE_ENABLE != 0) ? wr_ready_reg : '0;

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : gen_ch
            channel_state_t       state_reg;
            logic [IDX_W-1:0]     idx_reg;
            logic [IDX_W-1:0]     rr_reg;
            logic                 rd_valid_reg;
            logic [ADDR_BITS-1:0] rd_addr_reg;
            logic                 wr_valid_reg;
            logic [ADDR_BITS-1:0] wr_addr_reg;
            logic [DATA_BITS-1:0] wr_data_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg    <= CH_IDLE;
                    idx_reg      <= '0;
                    rr_reg       <= '0;
                    rd_valid_reg <= 1'b0;
                    rd_addr_reg  <= '0;
                    wr_valid_reg <= 1'b0;
                    wr_addr_reg  <= '0;
                    wr_data_reg  <= '0;
                end else begin
                    case (state_reg)
                        CH_IDLE: begin
                            if (grant_valid[gi]) begin
                                idx_reg <= grant_idx[gi];
                                rr_reg  <= (grant_idx[gi] == IDX_W'(NUM_CONSUMERS - 1))
                                           ? '0 : grant_idx[gi] + 1'b1;
                                if (grant_read[gi]) begin
                                    rd_valid_reg <= 1'b1;
                                    rd_addr_reg  <= consumer_read_address[grant_idx[gi]];
                                    state_reg    <= CH_READ_WAITING;
                                end else begin
                                    wr_valid_reg <= 1'b1;
                                    wr_addr_reg  <= consumer_write_address[grant_idx[gi]];
                                    wr_data_reg  <= consumer_write_data[grant_idx[gi]];
                                    state_reg    <= CH_WRITE_WAITING;
                                end
                            end
                        end
                        CH_READ_WAITING: begin
                            if (rd_done[gi]) begin
                                rd_valid_reg <= 1'b0;
                                state_reg    <= CH_READ_RELAYING;
                            end
                        end
                        CH_WRITE_WAITING: begin
                            if (wr_done[gi]) begin
                                wr_valid_reg <= 1'b0;
                                state_reg    <= CH_WRITE_RELAYING;
                            end
                        end
                        CH_READ_RELAYING: begin
                            if (rd_release[gi])
                                state_reg <= CH_IDLE;
                        end
                        CH_WRITE_RELAYING: begin
                            if (wr_release[gi])
                                state_reg <= CH_IDLE;
                        end
                        default: state_reg <= CH_IDLE;
                    endcase
                end
            end

            assign ch_state[gi]          = state_reg;
            assign ch_idx[gi]            = idx_reg;
            assign rr_ptr[gi]            = rr_reg;
            assign mem_read_valid[gi]    = rd_valid_reg;
            assign mem_read_address[gi]  = rd_addr_reg;
            assign mem_write_valid[gi]   = (WRITE_ENABLE != 0) && wr_valid_reg;
            assign mem_write_address[gi] = (WRITE_ENABLE != 0) ? wr_addr_reg : '0;
            assign mem_write_data[gi]    = (WRITE_ENABLE != 0) ? wr_data_reg : '0;
        end
    endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (1 channel, 2 channels,
// read-only) driven by one linear sequence of steps.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Instance A: N=4, M=1, writes enabled
    logic [3:0]       a_rv, a_rr, a_wv, a_wr;
    logic [3:0][7:0]  a_ra, a_rd, a_wa, a_wd;
    logic [0:0]       a_mrv, a_mrr, a_mwv, a_mwr;
    logic [0:0][7:0]  a_mra, a_mrd, a_mwa, a_mwd;

    // Instance B: N=4, M=2
    logic [3:0]       b_rv, b_rr, b_wv, b_wr;
    logic [3:0][7:0]  b_ra, b_rd, b_wa, b_wd;
    logic [1:0]       b_mrv, b_mrr, b_mwv, b_mwr;
    logic [1:0][7:0]  b_mra, b_mrd, b_mwa, b_mwd;

    // Instance C: N=4, M=1, read-only
    logic [3:0]       c_rv, c_rr, c_wv, c_wr;
    logic [3:0][7:0]  c_ra, c_rd, c_wa, c_wd;
    logic [0:0]       c_mrv, c_mrr, c_mwv, c_mwr;
    logic [0:0][7:0]  c_mra, c_mrd, c_mwa, c_mwd;

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(1)) dut_a (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
        .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
        .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
        .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
    );

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut_b (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
        .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
        .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
        .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
    );

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_c (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(c_mrv), .mem_read_address(c_mra),
        .mem_read_ready(c_mrr), .mem_read_data(c_mrd),
        .mem_write_valid(c_mwv), .mem_write_address(c_mwa),
        .mem_write_data(c_mwd), .mem_write_ready(c_mwr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        a_rv = '0; a_ra = '0; a_wv = '0; a_wa = '0; a_wd = '0;
        a_mrr = '0; a_mrd = '0; a_mwr = '0;
        b_rv = '0; b_ra = '0; b_wv = '0; b_wa = '0; b_wd = '0;
        b_mrr = '0; b_mrd = '0; b_mwr = '0;
        c_rv = '0; c_ra = '0; c_wv = '0; c_wa = '0; c_wd = '0;
        c_mrr = '0; c_mrd = '0; c_mwr = '0;

        // Reset state
        reset = 1'b1;
        tick(); tick();
        check("rst_a_mrv", 32'(a_mrv), 32'h0);
        check("rst_a_mwv", 32'(a_mwv), 32'h0);
        check("rst_a_rr",  32'(a_rr),  32'h0);
        check("rst_a_wr",  32'(a_wr),  32'h0);
        check("rst_a_rd",  32'(a_rd),  32'h0);
        check("rst_b_mrv", 32'(b_mrv), 32'h0);
        check("rst_c_mwv", 32'(c_mwv), 32'h0);
        reset = 1'b0;

        // Consumer 2 reads 0x10; memory answers 0xAB after 3 cycles
        a_rv[2] = 1'b1; a_ra[2] = 8'h10;
        tick();
        check("rd2_mrv_t1", 32'(a_mrv), 32'h1);
        check("rd2_mra",    32'(a_mra), 32'h10);
        tick(); tick();
        check("rd2_mrv_held", 32'(a_mrv), 32'h1);
        check("rd2_rr_early", 32'(a_rr),  32'h0);
        a_mrr = 1'b1; a_mrd = 8'hAB;
        tick();
        a_mrr = 1'b0; a_mrd = 8'h00;
        check("rd2_rr",       32'(a_rr),    32'h4);
        check("rd2_rd",       32'(a_rd[2]), 32'hAB);
        check("rd2_mrv_drop", 32'(a_mrv),   32'h0);
        tick();
        check("rd2_rr_hold", 32'(a_rr),    32'h4);
        check("rd2_rd_hold", 32'(a_rd[2]), 32'hAB);
        a_rv[2] = 1'b0;
        tick();
        check("rd2_release", 32'(a_rr), 32'h0);
        $display("txn: A consumer 2 read addr 0x10 data 0x%0h", a_rd[2]);

        // All four consumers read at once; pointer starts at 0 again
        reset = 1'b1; tick(); reset = 1'b0;
        a_rv = 4'hF;
        a_ra = {8'h43, 8'h42, 8'h41, 8'h40};
        for (int i = 0; i < 4; i++) begin
            waited = 0;
            while (!a_mrv[0] && waited < 6) begin
                tick();
                waited++;
            end
            check("all_grant_seen", 32'(a_mrv), 32'h1);
            check("all_grant_addr", 32'(a_mra), 32'(8'h40 + i));
            a_mrr = 1'b1; a_mrd = 8'(8'hC0 + i);
            tick();
            a_mrr = 1'b0;
            check("all_rr_onehot", 32'(a_rr),    32'(1 << i));
            check("all_rd",        32'(a_rd[i]), 32'(8'hC0 + i));
            $display("txn: A consumer %0d read addr 0x%0h data 0x%0h", i, 8'h40 + i, a_rd[i]);
            a_rv[i] = 1'b0;
            tick();
        end

        // Consumer 3 writes 0x5A to 0x22
        a_wv[3] = 1'b1; a_wa[3] = 8'h22; a_wd[3] = 8'h5A;
        tick();
        check("wr3_mwv", 32'(a_mwv), 32'h1);
        check("wr3_mwa", 32'(a_mwa), 32'h22);
        check("wr3_mwd", 32'(a_mwd), 32'h5A);
        check("wr3_mrv", 32'(a_mrv), 32'h0);
        tick();
        a_mwr = 1'b1;
        tick();
        a_mwr = 1'b0;
        check("wr3_wr",       32'(a_wr),  32'h8);
        check("wr3_mwv_drop", 32'(a_mwv), 32'h0);
        a_wv[3] = 1'b0;
        tick();
        check("wr3_release", 32'(a_wr), 32'h0);
        $display("txn: A consumer 3 write addr 0x22 data 0x5a");

        // Read and write together: only the read is serviced
        a_rv[0] = 1'b1; a_wv[0] = 1'b1; a_ra[0] = 8'h33; a_wa[0] = 8'h44; a_wd[0] = 8'h11;
        tick();
        check("rw_mrv", 32'(a_mrv), 32'h1);
        check("rw_mwv", 32'(a_mwv), 32'h0);
        check("rw_mra", 32'(a_mra), 32'h33);
        a_mrr = 1'b1; a_mrd = 8'h77;
        tick();
        a_mrr = 1'b0;
        check("rw_rr", 32'(a_rr),    32'h1);
        check("rw_rd", 32'(a_rd[0]), 32'h77);
        a_rv[0] = 1'b0; a_wv[0] = 1'b0;
        tick(); tick();
        check("rw_no_write", 32'(a_mwv), 32'h0);
        $display("txn: A consumer 0 read+write, read addr 0x33 data 0x%0h", a_rd[0]);

        // Reset while a read is waiting on memory
        a_rv[1] = 1'b1; a_ra[1] = 8'h55;
        tick();
        check("mid_mrv", 32'(a_mrv), 32'h1);
        reset = 1'b1;
        tick();
        check("mid_rst_mrv", 32'(a_mrv), 32'h0);
        check("mid_rst_rr",  32'(a_rr),  32'h0);
        check("mid_rst_wr",  32'(a_wr),  32'h0);
        reset = 1'b0; a_rv[1] = 1'b0;
        tick();
        a_rv[1] = 1'b1;
        tick();
        check("mid_regrant_mrv", 32'(a_mrv), 32'h1);
        check("mid_regrant_mra", 32'(a_mra), 32'h55);
        a_mrr = 1'b1; a_mrd = 8'h66;
        tick();
        a_mrr = 1'b0;
        check("mid_regrant_rr", 32'(a_rr), 32'h2);
        a_rv[1] = 1'b0;
        tick();
        $display("txn: A consumer 1 read abandoned by reset, reissued data 0x%0h", a_rd[1]);

        // Two channels, consumers 0 and 1 request in the same cycle
        b_rv[0] = 1'b1; b_rv[1] = 1'b1; b_ra[0] = 8'h60; b_ra[1] = 8'h61;
        tick();
        check("m2_mrv",  32'(b_mrv),    32'h3);
        check("m2_mra0", 32'(b_mra[0]), 32'h60);
        check("m2_mra1", 32'(b_mra[1]), 32'h61);
        b_mrr = 2'b10; b_mrd[1] = 8'hE1;
        tick();
        b_mrr = 2'b00;
        check("m2_rr_c1", 32'(b_rr),    32'h2);
        check("m2_rd_c1", 32'(b_rd[1]), 32'hE1);
        check("m2_mrv_c0_left", 32'(b_mrv), 32'h1);
        b_mrr = 2'b01; b_mrd[0] = 8'hE0;
        tick();
        b_mrr = 2'b00;
        check("m2_rr_both", 32'(b_rr),    32'h3);
        check("m2_rd_c0",   32'(b_rd[0]), 32'hE0);
        b_rv = '0;
        tick();
        check("m2_release", 32'(b_rr), 32'h0);
        $display("txn: B consumers 0/1 read in parallel data 0x%0h/0x%0h", b_rd[0], b_rd[1]);

        // Read-only instance ignores writes but still serves reads
        c_wv[0] = 1'b1; c_wa[0] = 8'h22; c_wd[0] = 8'h5A;
        c_rv[1] = 1'b1; c_ra[1] = 8'h70;
        tick();
        check("ro_mrv", 32'(c_mrv), 32'h1);
        check("ro_mra", 32'(c_mra), 32'h70);
        c_mrr = 1'b1; c_mrd = 8'h99;
        tick();
        c_mrr = 1'b0;
        check("ro_rr", 32'(c_rr),    32'h2);
        check("ro_rd", 32'(c_rd[1]), 32'h99);
        c_rv[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ro_no_mwv", 32'(c_mwv), 32'h0);
            check("ro_no_wr",  32'(c_wr),  32'h0);
        end
        c_wv = '0;
        $display("txn: C read-only, write request ignored, read data 0x%0h", c_rd[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
